mac_accumulator: RTL
====================

Name: mac_accumulator

Overview:
Downstream consumer of the 8x8 multiplier products. Accepts a stream of 16-bit products over a valid/ready handshake and sums a programmed number of terms. Operates in signed or unsigned mode, then presents the sum with a sticky overflow flag on an output valid/ready handshake. Turns the combinational multipliers into a dot-product / MAC datapath.

Parameters:
PROD_W, 16, product input width (matches the 8x8 multiplier Prod output)
ACC_W, 24, accumulator width; must be > PROD_W
LEN_W, 8, width of the term-count field

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a sum; honoured only in IDLE
len  input  LEN_W  number of products to sum; sampled with start
signed_mode  input  1  1 = two's-complement products and sum, 0 = unsigned; sampled with start
in_valid  input  1  in_prod is valid
in_ready  output  1  block accepts a product this cycle
in_prod  input  PROD_W  product from multiplier_signed / multiplier_unsigned
out_valid  output  1  out_acc / out_ovf are valid
out_ready  input  1  consumer accepts the result
out_acc  output  ACC_W  accumulated sum (wraps modulo 2^ACC_W)
out_ovf  output  1  sticky: at least one accumulation overflowed in the active mode
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, count=0, mode=0, ovf=0.
- Reset output values: in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0.
- Reset mid-operation aborts the sum; no partial result is ever presented.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with len!=0: latch len and signed_mode; clear acc, count and ovf; go to ACCUM.
  - start=1 with len==0: clear acc and ovf; go to DONE (empty sum = 0).
- ACCUM:
  - in_ready=1, decoded combinationally from state only.
  - A transfer occurs when in_valid && in_ready.
  - On a transfer: acc <= acc + ext(in_prod), count++.
  - ext = sign-extend to ACC_W if the latched mode is signed, else zero-extend.
  - No transfer: acc and count hold; gaps of any length are allowed.
  - Transfer with count == len-1: go to DONE. out_valid rises the next cycle, which is also the cycle the final sum appears on out_acc.
  - Throughput is one product per clock.
- DONE:
  - out_valid=1; out_acc and out_ovf are held stable.
  - out_ready=1: go to IDLE next cycle.
  - A new start is accepted no earlier than the cycle after returning to IDLE.
- start outside IDLE is ignored. The latched len and mode cannot change during ACCUM or DONE.
- Overflow, evaluated on every transfer and OR-ed into ovf:
  - unsigned: carry out of bit ACC_W-1.
  - signed: both addends have the same sign and the result sign differs.
- The sum always wraps; there is no saturation.
- out_acc is driven directly from the acc register; no combinational path from inputs to outputs except in_ready.

Decomposition:
- Shared package mac_pkg:
  - FSM state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2).
  - Default widths PROD_W/ACC_W/LEN_W.
- One sub-module is natural: acc_adder (ACC_W adder with mode input), producing sum and overflow.
  - It isolates the width-extension and overflow rules so they can be unit-tested alone.
- The FSM and counters stay in mac_accumulator.

Test Plan:
- Unsigned, len=2, products 255 (51*5) and 256 (16*16), back-to-back → out_acc=0x0001FF, out_ovf=0, out_valid asserted exactly one cycle after the second transfer.
- Signed, len=4, products 0x00FF, 0x0100, 0xFF01 (-51*5), 0xFF00 (16*-16) → out_acc=0x000000, out_ovf=0.
- Unsigned, len=2, products 0xFF01 and 0xFF00 → out_acc=0x01FE01 (zero-extended, 130561), out_ovf=0. Repeating the same products in signed mode gives 0xFFFE01 (-511).
- Instance with ACC_W=20, unsigned, len=17, all products 0xFFFF → out_acc=0x0FFEF, out_ovf=1.
- Handshake stress:
  - in_valid toggled 1,0,0,1,1; count advances only on transfers.
  - out_ready held low 3 cycles in DONE: out_valid/out_acc stable, and a start pulse is ignored.
  - out_ready=1 → IDLE, busy=0 the next cycle.
- Boundaries:
  - start with len=0 → DONE next cycle with out_acc=0.
  - rst_n pulsed low mid-ACCUM → all outputs 0 immediately (async); a following start with len=1 and product 0x0100 yields out_acc=0x000100.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator: FSM state encoding and default widths.
package mac_pkg;

  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mac_acc_adder.sv
// Accumulator adder: extends a product to ACC_W per mode and reports overflow of the add.
module acc_adder
  import mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              signed_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   full;

  // Upper bits replicate the product MSB only in signed mode.
  assign ext   = {{(ACC_W-PROD_W){prod_i[PROD_W-1] & signed_i}}, prod_i};
  assign full  = {1'b0, acc_i} + {1'b0, ext};
  assign sum_o = full[ACC_W-1:0];

  assign ovf_o = signed_i ? ((acc_i[ACC_W-1] == ext[ACC_W-1]) && (full[ACC_W-1] != acc_i[ACC_W-1]))
                          : full[ACC_W];

endmodule

// File: rtl/mac_accumulator.sv
// Sums a programmed number of products from a valid/ready stream and presents the
// wrapped sum with a sticky overflow flag on an output valid/ready handshake.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              signed_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               mode_q, mode_d;
  logic               ovf_q, ovf_d;
  logic               xfer;
  logic [ACC_W-1:0]   sum;
  logic               add_ovf;

  acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_i    (acc_q),
    .prod_i   (in_prod),
    .signed_i (mode_q),
    .sum_o    (sum),
    .ovf_o    (add_ovf)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign xfer      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          mode_d  = signed_mode;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_d   = sum;
          ovf_d   = ovf_q | add_ovf;
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
